// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow controller and scoreboard for two-player pong.
// Sequences NEWGAME -> PLAY -> NEWBALL/OVER, keeps both scores, declares the
// winner and times the serve and game-over pauses in frame_tick units.
//
// Optional feature macro: RALLY_CNT_EN (paddle-hit rally counter). When the
// macro is undefined rally_cnt is tied to zero and hit_A/hit_B are unused.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per frame
//   btn_start           debounced, synchronous start button
//   hit_A, hit_B        ball overlapping paddle A / B (levels)
//   miss_A, miss_B      ball passed paddle A / B (levels)
//   gra_still           1 = ball frozen at centre (every state but PLAY)
//   state               00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//   score_A, score_B    player points, binary
//   winner              00 none, 01 A, 10 B
//   rally_cnt           paddle hits in the current rally, saturating
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       hit_A,
  input  logic       hit_B,
  input  logic       miss_A,
  input  logic       miss_B,
  output logic       gra_still,
  output logic [1:0] state,
  output logic [3:0] score_A,
  output logic [3:0] score_B,
  output logic [1:0] winner,
  output logic [7:0] rally_cnt
);

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);
  localparam logic [7:0] OverFrames  = 8'(OVER_FRAMES);

  typedef enum logic [1:0] {
    StNewGame = 2'b00,
    StPlay    = 2'b01,
    StNewBall = 2'b10,
    StOver    = 2'b11
  } state_e;

  state_e     state_q;
  logic [7:0] timer_q;
  logic       btn_q;
  logic       start_rise;
  logic [3:0] score_a_inc;
  logic [3:0] score_b_inc;

  assign start_rise  = btn_start & ~btn_q;
  assign score_a_inc = score_A + 4'd1;
  assign score_b_inc = score_B + 4'd1;
  assign state       = state_q;

`ifdef RALLY_CNT_EN
  logic       hit_q;
  logic       hit_rise;
  logic [7:0] rally_q;
  assign hit_rise  = (hit_A | hit_B) & ~hit_q;
  assign rally_cnt = rally_q;
`else
  logic unused_hit;
  assign unused_hit = hit_A ^ hit_B;
  assign rally_cnt  = 8'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StNewGame;
      gra_still <= 1'b1;
      score_A   <= 4'd0;
      score_B   <= 4'd0;
      winner    <= 2'b00;
      timer_q   <= 8'd0;
      btn_q     <= 1'b0;
`ifdef RALLY_CNT_EN
      hit_q     <= 1'b0;
      rally_q   <= 8'd0;
`endif
    end else begin
      btn_q <= btn_start;
`ifdef RALLY_CNT_EN
      hit_q <= hit_A | hit_B;
`endif
      unique case (state_q)
        StNewGame: begin
          if (start_rise) begin
            state_q   <= StPlay;
            gra_still <= 1'b0;
            score_A   <= 4'd0;
            score_B   <= 4'd0;
            winner    <= 2'b00;
`ifdef RALLY_CNT_EN
            rally_q   <= 8'd0;
`endif
          end
        end
        StPlay: begin
          // Leaving PLAY on the first miss cycle makes a held miss count once.
          if (miss_A & miss_B) begin
            state_q   <= StNewBall;
            gra_still <= 1'b1;
            timer_q   <= ServeFrames;
          end else if (miss_A) begin
            score_B   <= score_b_inc;
            gra_still <= 1'b1;
            if (score_b_inc == WinScore) begin
              state_q <= StOver;
              winner  <= 2'b10;
              timer_q <= OverFrames;
            end else begin
              state_q <= StNewBall;
              timer_q <= ServeFrames;
            end
          end else if (miss_B) begin
            score_A   <= score_a_inc;
            gra_still <= 1'b1;
            if (score_a_inc == WinScore) begin
              state_q <= StOver;
              winner  <= 2'b01;
              timer_q <= OverFrames;
            end else begin
              state_q <= StNewBall;
              timer_q <= ServeFrames;
            end
          end
`ifdef RALLY_CNT_EN
          else if (hit_rise && (rally_q != 8'hFF)) begin
            rally_q <= rally_q + 8'd1;
          end
`endif
        end
        StNewBall: begin
          if (frame_tick) begin
            if (timer_q == 8'd1) begin
              state_q   <= StPlay;
              gra_still <= 1'b0;
`ifdef RALLY_CNT_EN
              rally_q   <= 8'd0;
`endif
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end
        end
        StOver: begin
          if (frame_tick) begin
            if (timer_q == 8'd1) begin
              state_q <= StNewGame;
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a cycle-level game model is
// compared with the DUT on every falling edge, plus literal checkpoints.
module tb_pong_game_ctrl;

  localparam int WinScore = 7;
  localparam int Serve    = 120;
  localparam int Over     = 180;
`ifdef RALLY_CNT_EN
  localparam bit RallyEn = 1'b1;
`else
  localparam bit RallyEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       hit_A = 1'b0;
  logic       hit_B = 1'b0;
  logic       miss_A = 1'b0;
  logic       miss_B = 1'b0;
  logic       gra_still;
  logic [1:0] state;
  logic [3:0] score_A;
  logic [3:0] score_B;
  logic [1:0] winner;
  logic [7:0] rally_cnt;

  int vectors = 0;
  int errors  = 0;

  pong_game_ctrl #(
    .WIN_SCORE   (WinScore),
    .SERVE_FRAMES(Serve),
    .OVER_FRAMES (Over)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .btn_start (btn_start),
    .hit_A     (hit_A),
    .hit_B     (hit_B),
    .miss_A    (miss_A),
    .miss_B    (miss_B),
    .gra_still (gra_still),
    .state     (state),
    .score_A   (score_A),
    .score_B   (score_B),
    .winner    (winner),
    .rally_cnt (rally_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Game model: phase 0 lobby, 1 rally in progress, 2 serve pause, 3 game over.
  int  m_phase = 0;
  int  m_pts_a = 0;
  int  m_pts_b = 0;
  int  m_win   = 0;
  int  m_hits  = 0;
  int  m_wait  = 0;
  bit  m_btn   = 0;
  bit  m_hit   = 0;
  bit  m_press;
  bit  m_touch;

  task automatic award(input bit to_a);
    if (to_a) m_pts_a++; else m_pts_b++;
    if (m_pts_a == WinScore || m_pts_b == WinScore) begin
      m_phase = 3;
      m_win   = to_a ? 1 : 2;
      m_wait  = Over;
    end else begin
      m_phase = 2;
      m_wait  = Serve;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_pts_a = 0; m_pts_b = 0; m_win = 0; m_hits = 0;
      m_wait = 0; m_btn = 0; m_hit = 0;
    end else begin
      m_press = btn_start && !m_btn;
      m_touch = (hit_A || hit_B) && !m_hit;
      m_btn   = btn_start;
      m_hit   = hit_A || hit_B;
      if (m_phase == 0) begin
        if (m_press) begin
          m_phase = 1; m_pts_a = 0; m_pts_b = 0; m_win = 0; m_hits = 0;
        end
      end else if (m_phase == 1) begin
        if (miss_A && miss_B) begin
          m_phase = 2; m_wait = Serve;
        end else if (miss_A) award(1'b0);
        else if (miss_B) award(1'b1);
        else if (RallyEn && m_touch && m_hits < 255) m_hits++;
      end else if (frame_tick) begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_phase == 2) m_hits = 0;
          m_phase = (m_phase == 2) ? 1 : 0;
        end
      end
    end
  end

  logic [20:0] exp_bus;
  logic [20:0] act_bus;
  always @(negedge clk) begin
    if (reset_n) begin
      exp_bus = {m_phase != 1, 2'(m_phase), 4'(m_pts_a), 4'(m_pts_b), 2'(m_win), 8'(m_hits)};
      act_bus = {gra_still, state, score_A, score_B, winner, rally_cnt};
      vectors++;
      if (act_bus !== exp_bus) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got %h expected %h", $time, act_bus, exp_bus);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      clks(1);
      frame_tick = 1'b0;
      clks(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    clks(3);
    chk("reset_state", state, 0);
    chk("reset_still", gra_still, 1);
    chk("reset_rally", rally_cnt, 0);
    reset_n = 1'b1;

    // Start button held 10 clocks: one transition to PLAY
    btn_start = 1'b1;
    clks(1);
    chk("start_play", state, 1);
    chk("start_still", gra_still, 0);
    clks(9);
    chk("start_held", state, 1);
    chk("start_score", score_A, 0);
    btn_start = 1'b0;

    // Held miss_B scores once, then a 120-tick serve
    miss_B = 1'b1;
    clks(5);
    miss_B = 1'b0;
    chk("missb_score", score_A, 1);
    chk("missb_state", state, 2);
    chk("missb_still", gra_still, 1);
    frames(Serve - 1);
    chk("serve_119", state, 2);
    frames(1);
    chk("serve_120", state, 1);

    // Rally counter
    hit_A = 1'b1; clks(3); hit_A = 1'b0; clks(1);
    hit_B = 1'b1; clks(2); hit_B = 1'b0; clks(1);
    chk("rally_two", rally_cnt, RallyEn ? 2 : 0);
    for (int i = 0; i < 300; i++) begin
      hit_A = 1'b1; clks(1); hit_A = 1'b0; clks(1);
    end
    chk("rally_sat", rally_cnt, RallyEn ? 255 : 0);
    miss_A = 1'b1; clks(1); miss_A = 1'b0;
    chk("missa_score", score_B, 1);
    chk("rally_held", rally_cnt, RallyEn ? 255 : 0);
    frames(Serve);
    chk("rally_clear", rally_cnt, 0);

    // Simultaneous misses: draw
    miss_A = 1'b1; miss_B = 1'b1; clks(1); miss_A = 1'b0; miss_B = 1'b0;
    chk("draw_state", state, 2);
    chk("draw_score_a", score_A, 1);
    chk("draw_score_b", score_B, 1);
    frames(Serve);

    // Bring A to 6, then win
    for (int i = 0; i < 5; i++) begin
      miss_B = 1'b1; clks(1); miss_B = 1'b0;
      frames(Serve);
    end
    chk("six_points", score_A, 6);
    miss_B = 1'b1; clks(1); miss_B = 1'b0;
    chk("win_score", score_A, 7);
    chk("win_state", state, 3);
    chk("win_winner", winner, 1);
    frames(Over - 1);
    chk("over_179", state, 3);
    frames(1);
    chk("over_180", state, 0);
    chk("over_held_a", score_A, 7);
    chk("over_held_w", winner, 1);
    miss_B = 1'b1; frames(3); miss_B = 1'b0;
    chk("newgame_ignore", score_A, 7);
    btn_start = 1'b1; clks(1);
    chk("restart_state", state, 1);
    chk("restart_score", score_A, 0);
    chk("restart_winner", winner, 0);
    clks(1);
    btn_start = 1'b0;

    // Async reset with the clock stopped mid-serve
    miss_B = 1'b1; clks(1); miss_B = 1'b0;
    frames(10);
    chk("pre_reset_state", state, 2);
    clk_run = 1'b0;
    #20;
    reset_n = 1'b0;
    #2;
    chk("async_state", state, 0);
    chk("async_score", score_A, 0);
    chk("async_still", gra_still, 1);
    #5;
    reset_n = 1'b1;
    #5;
    clk_run = 1'b1;
    clks(10);
    chk("post_reset_idle", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
